// File: rtl/counter_reg_mod_if.sv
// Control/status bundle for counter_reg_mod: master drives controls, slave is the counter.
// COUNTER_REG_STICKY_OVF_EN adds the ovf_sticky status line.
interface counter_reg_mod_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             up;
  logic [WIDTH-1:0] cr_data_output;
  logic             tc;
  logic             wrap;
`ifdef COUNTER_REG_STICKY_OVF_EN
  logic             ovf_sticky;
`endif

  modport master (
    output en, clr, load, load_data, up,
`ifdef COUNTER_REG_STICKY_OVF_EN
    input  ovf_sticky,
`endif
    input  cr_data_output, tc, wrap
  );

  modport slave (
    input  en, clr, load, load_data, up,
`ifdef COUNTER_REG_STICKY_OVF_EN
    output ovf_sticky,
`endif
    output cr_data_output, tc, wrap
  );
endinterface

// File: rtl/counter_reg_mod.sv
// Parametrised up/down modulo counter with prescaler, clear, load, tc and wrap pulse.
// Optional sticky overflow flag enabled by defining COUNTER_REG_STICKY_OVF_EN.
module counter_reg_mod #(
  parameter int     WIDTH    = 4,
  parameter longint MODULO   = 16,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  counter_reg_mod_if.slave bus
);

  localparam int               PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH-1:0] MAX_VAL = MAX_EXT[WIDTH-1:0];
  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(PRESCALE - 1);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_next;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [PRE_W-1:0] w_pre_next;
  logic             r_wrap;
  logic             w_wrap_event;
  logic             w_tick;
  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_load_val;

  // Extra top bit keeps MODULO = 2**WIDTH comparisons exact.
  assign w_at_max   = ({1'b0, r_cnt} == MAX_EXT);
  assign w_at_zero  = (r_cnt == '0);
  assign w_tick     = bus.en && (r_pre_cnt == PRE_TOP);
  assign w_load_val = ({1'b0, bus.load_data} > MAX_EXT) ? MAX_VAL : bus.load_data;

  always_comb begin
    w_cnt_next   = r_cnt;
    w_pre_next   = r_pre_cnt;
    w_wrap_event = 1'b0;
    if (bus.clr) begin
      w_cnt_next = '0;
      w_pre_next = '0;
    end else if (bus.load) begin
      w_cnt_next = w_load_val;
      w_pre_next = '0;
    end else begin
      if (bus.en) begin
        w_pre_next = w_tick ? '0 : r_pre_cnt + 1'b1;
      end
      if (w_tick) begin
        if (bus.up) begin
          if (w_at_max) begin
            w_cnt_next   = '0;
            w_wrap_event = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end else begin
          if (w_at_zero) begin
            w_cnt_next   = MAX_VAL;
            w_wrap_event = 1'b1;
          end else begin
            w_cnt_next = r_cnt - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_pre_cnt <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_pre_cnt <= w_pre_next;
      r_wrap    <= w_wrap_event;
    end
  end

  assign bus.cr_data_output = r_cnt;
  assign bus.wrap           = r_wrap;
  assign bus.tc             = bus.up ? w_at_max : w_at_zero;

`ifdef COUNTER_REG_STICKY_OVF_EN
  logic r_ovf;

  // Only clr or reset clear the flag; load leaves it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (bus.clr) begin
      r_ovf <= 1'b0;
    end else if (w_wrap_event) begin
      r_ovf <= 1'b1;
    end
  end

  assign bus.ovf_sticky = r_ovf;
`endif

endmodule

// File: tb/tb_counter_reg_mod.sv
// Scoreboard bench for counter_reg_mod: dut0 uses defaults, dut1 uses MODULO=10, PRESCALE=3.
module tb_counter_reg_mod;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  counter_reg_mod_if #(.WIDTH(4)) bus_a ();
  counter_reg_mod_if #(.WIDTH(4)) bus_b ();

  counter_reg_mod #(.WIDTH(4), .MODULO(16), .PRESCALE(1)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  counter_reg_mod #(.WIDTH(4), .MODULO(10), .PRESCALE(3)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  typedef struct {
    int         dut;
    string      name;
    logic [3:0] cnt;
    logic       tc;
    logic       wrap;
    logic       chk_ovf;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  event ev_check;

  task automatic cmp(input string nm, input int d, input string field,
                     input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d %s: got %0d expected %0d", nm, d, field, act, exp);
    end
  endtask

  task automatic push(input int d, input string nm, input logic [3:0] ecnt,
                      input logic etc, input logic ewrap,
                      input logic cov = 1'b0, input logic eovf = 1'b0);
    exp_t e;
    e.dut     = d;
    e.name    = nm;
    e.cnt     = ecnt;
    e.tc      = etc;
    e.wrap    = ewrap;
    e.chk_ovf = cov;
    e.ovf     = eovf;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, checked at the falling edge or on demand.
  initial begin
    forever begin
      @(negedge clk or ev_check);
      while (sb_q.size() > 0) begin
        exp_t       e;
        logic [3:0] a_cnt;
        logic       a_tc;
        logic       a_wrap;
        e = sb_q.pop_front();
        if (e.dut == 0) begin
          a_cnt = bus_a.cr_data_output; a_tc = bus_a.tc; a_wrap = bus_a.wrap;
        end else begin
          a_cnt = bus_b.cr_data_output; a_tc = bus_b.tc; a_wrap = bus_b.wrap;
        end
        $display("[%0t] %s dut%0d cnt=%0d tc=%0b wrap=%0b (exp %0d %0b %0b)",
                 $time, e.name, e.dut, a_cnt, a_tc, a_wrap, e.cnt, e.tc, e.wrap);
        cmp(e.name, e.dut, "count", a_cnt, e.cnt);
        cmp(e.name, e.dut, "tc", {3'b0, a_tc}, {3'b0, e.tc});
        cmp(e.name, e.dut, "wrap", {3'b0, a_wrap}, {3'b0, e.wrap});
`ifdef COUNTER_REG_STICKY_OVF_EN
        if (e.chk_ovf) begin
          logic a_ovf;
          a_ovf = (e.dut == 0) ? bus_a.ovf_sticky : bus_b.ovf_sticky;
          cmp(e.name, e.dut, "ovf_sticky", {3'b0, a_ovf}, {3'b0, e.ovf});
        end
`endif
      end
    end
  end

  task automatic drive(input int d, input logic en, input logic clr, input logic load,
                       input logic [3:0] ld, input logic up);
    if (d == 0) begin
      bus_a.en = en; bus_a.clr = clr; bus_a.load = load; bus_a.load_data = ld; bus_a.up = up;
      bus_b.en = 1'b0; bus_b.clr = 1'b0; bus_b.load = 1'b0;
    end else begin
      bus_b.en = en; bus_b.clr = clr; bus_b.load = load; bus_b.load_data = ld; bus_b.up = up;
      bus_a.en = 1'b0; bus_a.clr = 1'b0; bus_a.load = 1'b0;
    end
  endtask

  // Apply inputs for one edge and queue the state expected after that edge.
  task automatic step(input int d, input logic en, input logic clr, input logic load,
                      input logic [3:0] ld, input logic up, input string nm,
                      input logic [3:0] ecnt, input logic etc, input logic ewrap,
                      input logic cov = 1'b0, input logic eovf = 1'b0);
    drive(d, en, clr, load, ld, up);
    @(posedge clk);
    push(d, nm, ecnt, etc, ewrap, cov, eovf);
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] c;
    reset = 1'b0;
    bus_a.en = 1'b0; bus_a.clr = 1'b0; bus_a.load = 1'b0; bus_a.load_data = 4'd0; bus_a.up = 1'b1;
    bus_b.en = 1'b0; bus_b.clr = 1'b0; bus_b.load = 1'b0; bus_b.load_data = 4'd0; bus_b.up = 1'b1;
    #2;
    push(0, "reset", 4'd0, 1'b0, 1'b0);
    push(1, "reset", 4'd0, 1'b0, 1'b0);
    -> ev_check;
    @(negedge clk);
    #1;
    reset = 1'b1;

    for (int i = 1; i <= 18; i++) begin
      c = 4'(i % 16);
      step(0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, "up_seq", c, (c == 4'd15), (i == 16));
    end
    for (int i = 3; i <= 7; i++) begin
      step(0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, "up_to_7", 4'(i), 1'b0, 1'b0);
    end

    // Asynchronous reset in the low phase, checked before any further clock edge.
    #2;
    reset = 1'b0;
    #1;
    push(0, "async_rst", 4'd0, 1'b0, 1'b0);
    push(1, "async_rst", 4'd0, 1'b0, 1'b0);
    -> ev_check;
    @(negedge clk);
    #1;
    reset = 1'b1;
    step(0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, "resume", 4'd1, 1'b0, 1'b0);

    step(0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "clr", 4'd0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "down_wrap", 4'd15, 1'b0, 1'b1);
    step(0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "down", 4'd14, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "down", 4'd13, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "hold", 4'd13, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, "load0_tc", 4'd0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, "dir_up", 4'd1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1, 1'b1, 4'd5, 1'b1, "clr_over_load", 4'd0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0, 1'b1, 4'd12, 1'b1, "load12", 4'd12, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0, 1'b1, 4'd12, 1'b1, "load_clamp", 4'd9, 1'b1, 1'b0);

    // Prescaled counting on dut1 with an en=0 gap mid-run.
    step(1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, "b_clr", 4'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      c = 4'((k / 3) % 10);
      step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, "b_count", c, (c == 4'd9), 1'b0);
    end
    for (int k = 0; k < 5; k++) begin
      step(1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, "b_hold", 4'd4, 1'b0, 1'b0);
    end
    for (int k = 14; k <= 31; k++) begin
      c = 4'((k / 3) % 10);
      step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, "b_count", c, (c == 4'd9), (k == 30));
    end

    step(1, 1'b1, 1'b0, 1'b1, 4'd2, 1'b1, "b_load_en", 4'd2, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, "b_after_load", 4'd2, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, "b_after_load", 4'd2, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, "b_after_load", 4'd3, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "b_dir_down", 4'd3, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "b_dir_down", 4'd3, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "b_dir_down", 4'd2, 1'b0, 1'b0);

`ifdef COUNTER_REG_STICKY_OVF_EN
    step(0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "ovf_clr0", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "ovf_set", 4'd15, 1'b0, 1'b1, 1'b1, 1'b1);
    step(0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, "ovf_load", 4'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    step(0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "ovf_hold", 4'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    step(0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "ovf_clear", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
`endif

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_reg_mod.md
Name: counter_reg_mod

Overview:
Parametrised up/down counter register; next generation of the team's fixed 4-bit counter register.
- Adds configurable width and modulus, clock-enable prescaler, synchronous clear, parallel load, direction control, terminal-count and wrap indications.
- Used as a general event/timebase counter inside register-file and control datapaths.

Parameters:
WIDTH, 4, bit width of the count register (1..32).
MODULO, 16, count range 0..MODULO-1; legal 2..2**WIDTH.
PRESCALE, 1, number of enabled cycles per count step; legal 1..65535.

Ports:
clk  in  1  system clock, rising-edge active.
reset  in  1  asynchronous, active-low reset.
en  in  1  count enable; gates the prescaler.
clr  in  1  synchronous clear.
load  in  1  synchronous parallel load.
load_data  in  WIDTH  value loaded when load=1.
up  in  1  direction: 1 = up, 0 = down.
cr_data_output  out  WIDTH  current count value (registered).
tc  out  1  terminal count (combinational from registered state).
wrap  out  1  one-cycle registered pulse on a wrap event.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0, asynchronous): cr_data_output=0, internal prescaler pre_cnt=0, wrap=0. Takes effect immediately, including mid-count or mid-load. Release is synchronous to clk.
- Per rising edge, priority clr > load > count.
- clr=1: cr_data_output<=0, pre_cnt<=0, wrap<=0.
- load=1 (clr=0): cr_data_output<=load_data, clamped to MODULO-1 if load_data>=MODULO. Also pre_cnt<=0, wrap<=0.
- Prescaler: when en=1 and no clr/load, pre_cnt increments; tick asserts when pre_cnt==PRESCALE-1, and pre_cnt<=0 on that edge. PRESCALE=1 means tick=en. en=0 holds pre_cnt.
- Count on tick:
  - up=1: value MODULO-1 goes to 0 with wrap event; otherwise +1.
  - up=0: value 0 goes to MODULO-1 with wrap event; otherwise -1.
- Non-tick cycles hold the count.
- wrap: registered; equals 1 for exactly the one cycle following the edge on which the wrap event occurred; otherwise 0.
- tc: 1 when (up=1 and count==MODULO-1) or (up=0 and count==0), irrespective of en.
- Direction change takes effect on the next tick; pre_cnt is not disturbed.
- MODULO=2**WIDTH: natural binary wrap; arithmetic is done in WIDTH+1 bits internally to avoid overflow on the comparison.
- Latency: count changes one clk edge after the tick condition is sampled.

Optional Feature:
COUNTER_REG_STICKY_OVF_EN
- Defined: adds output port ovf_sticky (1 bit).
  - Set on the edge of any wrap event.
  - Remains 1 until clr=1 or reset=0.
  - load does not clear it.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. Defaults, reset=0 then 1, en=1, up=1 for 18 cycles -> count 0,1..15,0,1; wrap=1 only in the cycle after 15->0; tc=1 while count=15.
2. MODULO=10, PRESCALE=3, en=1, up=1 -> count steps every 3rd cycle; 9->0 wrap after 30 enabled cycles; en=0 for 5 cycles mid-run holds both count and prescaler phase.
3. Defaults, up=0 from reset -> first tick gives 15 with wrap pulse; tc=1 at count 0 and 0 at 15.
4. load=1 with load_data=5 together with clr=1 -> count 0. Then load=1, load_data=12 with MODULO=10 -> count 9. Then load and en on the same edge -> load wins, pre_cnt restarts at 0.
5. reset asserted asynchronously between clock edges at count 7 -> output 0 without a clk edge. After release, counting resumes from 0 on the first enabled tick.
6. With COUNTER_REG_STICKY_OVF_EN defined: force a wrap -> ovf_sticky=1; load 3 -> ovf_sticky still 1; clr -> ovf_sticky=0.
